// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion arbiter and its serial engine.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BITS_PER_NYBBLE     = 4;
    localparam int BCD_BITS_PER_NYBBLE = 6;
    localparam int BCD_DIGIT_BITS      = 4;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADD3_CONST     = 4'd3;

    function automatic int input_bits(input int nybbles);
        return nybbles * BITS_PER_NYBBLE;
    endfunction

    // Six BCD bits per hex nybble always covers the decimal width of the operand.
    function automatic int output_bits(input int nybbles);
        return nybbles * BCD_BITS_PER_NYBBLE;
    endfunction

endpackage

// File: rtl/bcd_serial_engine.sv
// Bit-serial double-dabble binary-to-BCD converter: one add-3/shift step per enabled cycle.
module bcd_serial_engine
    import bcd_pkg::*;
#(
    parameter  int INPUT_NYBBLES = 2,
    localparam int INPUT_BITS    = input_bits(INPUT_NYBBLES),
    localparam int OUTPUT_BITS   = output_bits(INPUT_NYBBLES)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [INPUT_BITS-1:0]  operand,
    input  logic                   step_en,
    output logic                   done,
    output logic [OUTPUT_BITS-1:0] result
);

    localparam int DIGITS = OUTPUT_BITS / BCD_DIGIT_BITS;
    localparam int CNT_W  = $clog2(INPUT_BITS + 1);

    logic [OUTPUT_BITS-1:0] acc;
    logic [OUTPUT_BITS-1:0] acc_adj;
    logic [INPUT_BITS-1:0]  opnd;
    logic [CNT_W-1:0]       count;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[d*BCD_DIGIT_BITS +: BCD_DIGIT_BITS] >= ADD3_THRESHOLD) begin
                acc_adj[d*BCD_DIGIT_BITS +: BCD_DIGIT_BITS] =
                    acc[d*BCD_DIGIT_BITS +: BCD_DIGIT_BITS] + ADD3_CONST;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            count <= '0;
        end else if (start) begin
            acc   <= '0;
            count <= CNT_W'(INPUT_BITS);
        end else if (step_en && (count != '0)) begin
            acc   <= {acc_adj, opnd[INPUT_BITS-1]} ;
            count <= count - CNT_W'(1);
        end
    end

    // Operand shift register carries no reset; it is reloaded at every start.
    always_ff @(posedge clock) begin
        if (start) begin
            opnd <= operand;
        end else if (step_en && (count != '0)) begin
            opnd <= {opnd[INPUT_BITS-2:0], 1'b0};
        end
    end

    assign done   = step_en && (count == CNT_W'(1));
    assign result = acc;

endmodule

// File: rtl/bcd_conversion_arbiter.sv
// Arbitrates NUM_REQUESTERS binary operands onto one serial BCD converter.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed lowest-index priority.
module bcd_conversion_arbiter
    import bcd_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int INPUT_NYBBLES  = 2,
    localparam int INPUT_BITS     = input_bits(INPUT_NYBBLES),
    localparam int OUTPUT_BITS    = output_bits(INPUT_NYBBLES),
    localparam int ID_W           = $clog2(NUM_REQUESTERS)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [NUM_REQUESTERS-1:0]          req_valid,
    input  logic [NUM_REQUESTERS*INPUT_BITS-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]          req_ready,
    output logic                               result_valid,
    output logic [OUTPUT_BITS-1:0]             result_bcd,
    output logic [ID_W-1:0]                    result_id,
    input  logic                               result_ready,
    output logic                               busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              eng_start;
    logic              eng_step;
    logic              eng_done;
    logic [INPUT_BITS-1:0] operand;

`ifdef BCD_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= ID_W'(NUM_REQUESTERS - 1);
        end else if (eng_start) begin
            rr_ptr <= grant_idx;
        end
    end

    // Search upward from the slot after the last grant, wrapping around.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQUESTERS]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQUESTERS);
            end
        end
    end
`else
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_step  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    eng_start = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                eng_step = 1'b1;
                if (eng_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_id <= '0;
        end else if (eng_start) begin
            result_id <= grant_idx;
        end
    end

    // Gated by reset_n so the strobe drops the instant reset asserts.
    always_comb begin
        req_ready = '0;
        if (reset_n && (state == IDLE) && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign operand      = req_data[grant_idx*INPUT_BITS +: INPUT_BITS];
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

    bcd_serial_engine #(
        .INPUT_NYBBLES (INPUT_NYBBLES)
    ) u_engine (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (eng_start),
        .operand (operand),
        .step_en (eng_step),
        .done    (eng_done),
        .result  (result_bcd)
    );

endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// Scoreboard bench for bcd_conversion_arbiter (default parameters).
module tb_bcd_conversion_arbiter;

    localparam int N  = 4;
    localparam int IB = 8;
    localparam int OB = 12;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*IB-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          result_valid;
    logic [OB-1:0] result_bcd;
    logic [1:0]    result_id;
    logic          result_ready = 1'b1;
    logic          busy;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [11:0] bcd;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];

    bcd_conversion_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .result_valid (result_valid),
        .result_bcd   (result_bcd),
        .result_id    (result_id),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t make_exp(input int v, input int id);
        exp_t e;
        e.bcd = to_bcd(v);
        e.id  = 2'(id);
        return e;
    endfunction

    // Raises req_valid[idx] and waits (bounded) for its grant; leaves valid high before the accept edge.
    task automatic drive_request(input int idx, input logic [7:0] data, output int wait_cycles);
        @(negedge clock);
        req_data[idx*IB +: IB] = data;
        req_valid[idx] = 1'b1;
        #1;
        wait_cycles = 0;
        while (req_ready[idx] !== 1'b1 && wait_cycles < 40) begin
            @(negedge clock);
            #1;
            wait_cycles++;
        end
        if (req_ready[idx] === 1'b1) sb.push_back(make_exp(int'(data), idx));
        else wait_cycles = -1;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (result_valid === 1'b1) return;
        end
        edges = -1;
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() > 0);
        e  = '0;
        if (ok) e = sb.pop_front();
    endtask

    task automatic test_reset();
        #1;
        reset_n   = 1'b0;
        req_valid = 4'b0101;
        #2;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else passes++;
        checks++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b expected 0", result_valid); else passes++;
        checks++; if (result_bcd !== 12'h000) $display("FAIL reset_result_bcd: got %h expected 000", result_bcd); else passes++;
        checks++; if (result_id !== 2'd0) $display("FAIL reset_result_id: got %0d expected 0", result_id); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single_ff();
        int w, edges;
        exp_t e;
        bit ok;
        result_ready = 1'b1;
        drive_request(0, 8'hFF, w);
        checks++; if (w < 0) $display("FAIL ff_grant_timeout: got no grant expected grant"); else passes++;
        checks++; if (req_ready !== 4'b0001) $display("FAIL ff_req_ready: got %b expected 0001", req_ready); else passes++;
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) $display("FAIL ff_after_accept: got ready=%b busy=%b expected 0000/1", req_ready, busy); else passes++;
        wait_result(edges);
        checks++; if (edges != 8) $display("FAIL ff_latency: got %0d expected 8", edges); else passes++;
        pop_exp(e, ok);
        checks++; if (!ok || result_bcd !== e.bcd || result_bcd !== 12'h255) $display("FAIL ff_bcd: got %h expected %h", result_bcd, e.bcd); else passes++;
        checks++; if (!ok || result_id !== e.id) $display("FAIL ff_id: got %0d expected %0d", result_id, e.id); else passes++;
        @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL ff_return_idle: got busy=%b valid=%b expected 0/0", busy, result_valid); else passes++;
    endtask

    task automatic test_zero();
        int w, edges;
        exp_t e;
        bit ok;
        drive_request(2, 8'h00, w);
        checks++; if (w < 0 || req_ready !== 4'b0100) $display("FAIL zero_grant: got %b expected 0100", req_ready); else passes++;
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        wait_result(edges);
        pop_exp(e, ok);
        checks++; if (edges != 8 || !ok || result_bcd !== e.bcd) $display("FAIL zero_bcd: got %h after %0d edges expected %h after 8", result_bcd, edges, e.bcd); else passes++;
        checks++; if (!ok || result_id !== e.id) $display("FAIL zero_id: got %0d expected %0d", result_id, e.id); else passes++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_all_valid();
        int n, edges, exp_g;
        int vals [4] = '{8'h0A, 8'h63, 8'h80, 8'hC8};
        exp_t e;
        bit ok;
        @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        result_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*IB +: IB] = 8'(vals[i]);
        req_valid = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            #1;
            n = 0;
            while (req_ready === 4'b0000 && n < 40) begin
                @(negedge clock);
                #1;
                n++;
            end
`ifdef BCD_ARB_ROUND_ROBIN_EN
            exp_g = r;
`else
            exp_g = 0;
`endif
            sb.push_back(make_exp(vals[exp_g], exp_g));
            checks++; if (req_ready !== (4'b0001 << exp_g)) $display("FAIL all_grant_%0d: got %b expected one-hot %0d", r, req_ready, exp_g); else passes++;
            @(posedge clock);
            #1;
`ifdef BCD_ARB_ROUND_ROBIN_EN
            req_valid[exp_g] = 1'b0;
`endif
            wait_result(edges);
            pop_exp(e, ok);
            checks++; if (edges < 0 || !ok || result_bcd !== e.bcd || result_id !== e.id) $display("FAIL all_result_%0d: got %h id %0d expected %h id %0d", r, result_bcd, result_id, e.bcd, e.id); else passes++;
            @(posedge clock);
        end
        #1;
        req_valid = '0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int w, edges, bad;
        exp_t e;
        bit ok;
        result_ready = 1'b0;
        drive_request(3, 8'h39, w);
        @(posedge clock);
        #1;
        req_valid[3] = 1'b0;
        wait_result(edges);
        checks++; if (edges != 8) $display("FAIL bp_latency: got %0d expected 8", edges); else passes++;
        req_data[1*IB +: IB] = 8'h11;
        req_valid[1] = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (result_valid !== 1'b1 || sb.size() == 0 || result_bcd !== sb[0].bcd || result_id !== 2'd3 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold_cycle_%0d: got valid=%b bcd=%h id=%0d busy=%b ready=%b expected 1/057/3/1/0000", c, result_valid, result_bcd, result_id, busy, req_ready);
            end
        end
        checks++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else passes++;
        pop_exp(e, ok);
        checks++; if (!ok || result_bcd !== e.bcd || result_id !== e.id) $display("FAIL bp_result: got %h id %0d expected %h id %0d", result_bcd, result_id, e.bcd, e.id); else passes++;
        req_valid[1] = 1'b0;
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL bp_release: got busy=%b valid=%b expected 0/0", busy, result_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        int w, edges, seen;
        exp_t e;
        bit ok;
        result_ready = 1'b1;
        drive_request(3, 8'h7B, w);
        @(posedge clock);
        #1;
        req_valid[3] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        checks++; if (result_valid !== 1'b0 || result_bcd !== 12'h000 || result_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL midreset_outputs: got valid=%b bcd=%h id=%0d busy=%b ready=%b expected all zero", result_valid, result_bcd, result_id, busy, req_ready);
        else passes++;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (result_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) $display("FAIL midreset_no_result: got %0d valid cycles expected 0", seen); else passes++;
        drive_request(1, 8'h2A, w);
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        wait_result(edges);
        pop_exp(e, ok);
        checks++; if (edges != 8 || !ok || result_bcd !== e.bcd || result_id !== e.id) $display("FAIL midreset_recover: got %h id %0d after %0d edges expected %h id %0d", result_bcd, result_id, edges, e.bcd, e.id); else passes++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_drop();
        int w, edges, saw1, res1;
        exp_t e;
        bit ok;
        result_ready = 1'b1;
        drive_request(2, 8'h63, w);
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clock);
        #1;
        req_data[1*IB +: IB] = 8'h55;
        req_valid[1] = 1'b1;
        saw1 = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (req_ready[1] === 1'b1) saw1++;
        end
        req_valid[1] = 1'b0;
        wait_result(edges);
        pop_exp(e, ok);
        checks++; if (edges < 0 || !ok || result_bcd !== e.bcd || result_id !== e.id) $display("FAIL drop_result: got %h id %0d expected %h id %0d", result_bcd, result_id, e.bcd, e.id); else passes++;
        res1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (req_ready[1] === 1'b1) saw1++;
            if (result_valid === 1'b1) res1++;
        end
        checks++; if (saw1 != 0) $display("FAIL drop_grant1: got %0d grants expected 0", saw1); else passes++;
        checks++; if (res1 != 0) $display("FAIL drop_extra_result: got %0d results expected 0", res1); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_ff();
        test_zero();
        test_all_valid();
        test_backpressure();
        test_reset_mid();
        test_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conversion_arbiter.md
BCD_CONVERSION_ARBITER -- requirements
Module: bcd_conversion_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter INPUT_NYBBLES, default 2, hex nybbles per request; INPUT_BITS = INPUT_NYBBLES*4 and OUTPUT_BITS = INPUT_NYBBLES*6 are derived.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQUESTERS, per-requester request pending.
REQ-006 SHALL have port req_data, input, NUM_REQUESTERS*INPUT_BITS, binary operands; requester i occupies bits [i*INPUT_BITS +: INPUT_BITS].
REQ-007 SHALL have port req_ready, output, NUM_REQUESTERS, one-hot accept strobe.
REQ-008 SHALL have port result_valid, output, 1, result available.
REQ-009 SHALL have port result_bcd, output, OUTPUT_BITS, packed BCD result, least significant digit in bits [3:0].
REQ-010 SHALL have port result_id, output, clog2(NUM_REQUESTERS), index of the requester that owns the result.
REQ-011 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, CONVERT and DONE.
REQ-014 In IDLE, when any req_valid bit is high, SHALL assert exactly one req_ready bit combinationally for the granted index in the same cycle; that cycle is the accept.
REQ-015 At the accept edge SHALL capture the granted req_data and its index, clear the BCD accumulator, load step counter = INPUT_BITS and enter CONVERT.
REQ-016 In CONVERT, each cycle SHALL perform one double-dabble step: add 3 to every accumulator nybble >= 5, then shift the combined {accumulator, operand} left by one; counter decrements.
REQ-017 On the edge completing step INPUT_BITS, SHALL enter DONE with result_valid high; result_valid therefore rises INPUT_BITS edges after the accept edge (8 for default).
REQ-018 In DONE, SHALL hold result_valid, result_bcd and result_id stable until result_valid and result_ready are both high at an edge, then return to IDLE.
REQ-019 SHALL keep req_ready all-zero outside IDLE; no requests are accepted until the next IDLE cycle, giving one idle cycle between results.
REQ-020 If a requester deasserts req_valid before being granted, SHALL drop it without side effects; req_data is sampled only at the accept.
REQ-021 SHALL ignore result_ready outside DONE.
REQ-022 SHALL make result_bcd equal the decimal value of the operand, upper unused digits zero (8'hFF -> 12'h255).

Reset
REQ-023 On reset_n low, SHALL asynchronously force IDLE, counter 0, req_ready 0, result_valid 0, result_bcd 0, result_id 0, busy 0, round-robin pointer to NUM_REQUESTERS-1.
REQ-024 Reset asserted mid-conversion or in DONE SHALL discard the transaction; no result for it is produced after reset_n is released.

Configuration
REQ-025 With macro BCD_ARB_ROUND_ROBIN_EN defined, SHALL grant the first valid index searching upward (with wrap) from last-granted+1; the pointer updates only at an accept.
REQ-026 Without BCD_ARB_ROUND_ROBIN_EN, SHALL grant the lowest-index valid requester (fixed priority) and omit the pointer register.

Structure
REQ-027 SHALL place the derived widths, the FSM state encoding and the nybble add-3 threshold (5) and add-3 constant (3) in shared package bcd_pkg.
REQ-028 SHALL implement the shift/adjust datapath as sub-module bcd_serial_engine (start, operand, step enable, done, result); arbitration and FSM remain in the top.

Verification
REQ-029 Requester 0 sends 8'hFF, result_ready tied high -> req_ready = 4'b0001 for one cycle; result_bcd = 12'h255, result_id = 0, result_valid 8 edges after the accept.
REQ-030 Requester 2 sends 8'h00 -> result_bcd = 12'h000, result_id = 2.
REQ-031 All four valid, operands 8'h0A/8'h63/8'h80/8'hC8, round-robin build -> grants 0,1,2,3 with results 12'h010, 12'h099, 12'h128, 12'h200; fixed-priority build with valids held -> requester 0 is granted every time.
REQ-032 result_ready held low 20 cycles in DONE -> outputs stable, busy high, req_ready 0; release -> IDLE next edge.
REQ-033 reset_n pulsed low at step 4 of the conversion of 8'h7B -> outputs zero immediately, no result_valid after release; a new request then converts normally.
REQ-034 Requester 1 raises then drops req_valid while a conversion is in progress -> it is never granted and no result is produced with result_id = 1.
